// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for register_pipeline and its capture FIFO.
package pipeline_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_SIZE   = 8;
  localparam int DROP_CNT_W = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous read port.
module fifo_regfile
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipeline_capture_fifo.sv
// First-word-fall-through capture FIFO behind register_pipeline; almost_full throttles the pipeline.
// Define PIPELINE_CAPTURE_FIFO_STATS_EN to add the overflow / drop_count outputs.
module pipeline_capture_fifo
  import pipeline_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 8,
  localparam int AW          = clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  almost_full,
  output logic                  full,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
`ifdef PIPELINE_CAPTURE_FIFO_STATS_EN
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
`endif
  output logic [CW-1:0]         count
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full        = (r_count == CW'(DEPTH));
  assign almost_full = (r_count >= CW'(DEPTH - AFULL_MARGIN));
  assign out_valid   = (r_count != '0);
  assign count       = r_count;

  assign w_pop  = out_valid & out_ready;
  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign w_push = in_valid & (~full | w_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (out_data)
  );

`ifdef PIPELINE_CAPTURE_FIFO_STATS_EN
  logic                  w_drop;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_count;

  assign w_drop = in_valid & ~w_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_pipeline_capture_fifo.sv
// Scoreboard bench for pipeline_capture_fifo: reset, fill, overflow, full push+pop, empty bypass, chained pipeline.
module tb_pipeline_capture_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int SIZE  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             almost_full;
  logic             full;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
`ifdef PIPELINE_CAPTURE_FIFO_STATS_EN
  logic             overflow;
  logic [15:0]      drop_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q[$];
  int               m_count = 0;
  int               m_drop  = 0;

  always #5 clk = ~clk;

  pipeline_capture_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .almost_full (almost_full),
    .full        (full),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
`ifdef PIPELINE_CAPTURE_FIFO_STATS_EN
    .overflow    (overflow),
    .drop_count  (drop_count),
`endif
    .count       (count)
  );

  // One clock cycle: drive inputs, predict push/pop, advance, compare against the model.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
    logic             m_pop;
    logic             m_push;
    logic [WIDTH-1:0] exp_head;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    m_pop  = (m_count != 0) && rdy;
    m_push = v && ((m_count != DEPTH) || m_pop);
    if (m_pop) begin
      exp_head = q.pop_front();
      total++;
      if (out_data !== exp_head) begin
        bad++;
        $display("FAIL pop_data: got %h expected %h", out_data, exp_head);
      end
    end
    if (m_push) q.push_back(d);
    if (v && !m_push && m_drop != 16'hFFFF) m_drop++;
    m_count = m_count + int'(m_push) - int'(m_pop);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (count !== m_count[CW-1:0]) begin
      bad++;
      $display("FAIL count: got %0d expected %0d", count, m_count);
    end
    total++;
    if (out_valid !== (m_count != 0) || full !== (m_count == DEPTH) ||
        almost_full !== (m_count >= 8)) begin
      bad++;
      $display("FAIL flags: got v/f/af=%b%b%b expected %b%b%b", out_valid, full, almost_full,
               m_count != 0, m_count == DEPTH, m_count >= 8);
    end
    if (m_count != 0) begin
      total++;
      if (out_data !== q[0]) begin
        bad++;
        $display("FAIL head_data: got %h expected %h", out_data, q[0]);
      end
    end
`ifdef PIPELINE_CAPTURE_FIFO_STATS_EN
    total++;
    if (overflow !== (m_drop != 0) || drop_count !== 16'(m_drop)) begin
      bad++;
      $display("FAIL stats: got ovf=%b drops=%0d expected ovf=%b drops=%0d", overflow, drop_count,
               m_drop != 0, m_drop);
    end
`endif
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    m_count = 0;
    m_drop  = 0;
    total++;
    if (count !== '0 || out_valid !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got count=%0d v/f/af=%b%b%b expected 0 000", count, out_valid,
               full, almost_full);
    end
`ifdef PIPELINE_CAPTURE_FIFO_STATS_EN
    total++;
    if (overflow !== 1'b0 || drop_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_stats: got ovf=%b drops=%0d expected 0 0", overflow, drop_count);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset(2);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0);
    do_reset(2);
    step(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 1'b0);
  endtask

  task automatic test_full_push_pop();
    step(1'b1, 16'hBEEF, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_empty_bypass();
    step(1'b1, 16'h00AA, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_pipeline_chain();
    logic             pv[SIZE];
    logic [WIDTH-1:0] pd[SIZE];
    logic             en;
    logic             v;
    logic [WIDTH-1:0] dd;
    logic             busy;
    int               sent;
    int               cyc;
    sent = 0;
    cyc  = 0;
    for (int i = 0; i < SIZE; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    busy = 1'b1;
    while (busy && cyc < 2000) begin
      en = ~almost_full;
      v  = en & pv[SIZE-1];
      dd = pd[SIZE-1];
      if (en) begin
        for (int i = SIZE - 1; i > 0; i--) begin
          pv[i] = pv[i-1];
          pd[i] = pd[i-1];
        end
        pv[0] = (sent < 40);
        pd[0] = 16'($urandom);
        if (sent < 40) sent++;
      end
      step(v, dd, 1'($urandom_range(0, 1)));
      total++;
      if (count > 5'd16) begin
        bad++;
        $display("FAIL chain_count_bound: got %0d expected <= 16", count);
      end
      cyc++;
      busy = (sent < 40) || (q.size() != 0);
      for (int i = 0; i < SIZE; i++) busy = busy | pv[i];
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL chain_timeout: got %0d cycles expected drain before 2000", cyc);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_mid_reset();
    test_fill();
    test_overflow();
    test_full_push_pop();
    test_empty_bypass();
    test_pipeline_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
